// File: rtl/rob_commit.sv
// ---------------------------------------------------------------------------
// rob_commit -- 8-entry circular reorder buffer for the Tomasulo core.
//
// Allocates a ROB index at issue, captures results broadcast by exec, retires
// them in program order (one per cycle) to the register bank, and flushes the
// whole buffer one cycle after retiring a mispredicted branch. Also answers
// operand-forwarding lookups from the issue stage.
//
// Ports:
//   clk1, rst            clock (rising edge), synchronous active-high reset
//   alloc_valid/func/rd  issue-side allocate request
//   alloc_ready          comb: room available and not flushing
//   alloc_idx            comb: index granted to this cycle's allocate (= tail)
//   wb_valid/rob_ind/data  exec result broadcast (branch: data[0]=mispredict)
//   commit_*             registered one-cycle retire pulse and its payload
//   flush                registered one-cycle pulse after a mispredict retires
//   q_idx/q_ready/q_data comb operand lookup by ROB index
//   count                occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module rob_commit #(
   parameter int DEPTH  = 8,
   parameter int IDX_W  = 3,
   parameter int DATA_W = 16
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              alloc_valid,
   input  logic [3:0]        alloc_func,
   input  logic [3:0]        alloc_rd,
   output logic              alloc_ready,
   output logic [IDX_W-1:0]  alloc_idx,
   input  logic              wb_valid,
   input  logic [IDX_W-1:0]  wb_rob_ind,
   input  logic [DATA_W-1:0] wb_data,
   output logic              commit_valid,
   output logic              commit_we,
   output logic [3:0]        commit_rd,
   output logic [DATA_W-1:0] commit_data,
   output logic [IDX_W-1:0]  commit_rob_ind,
   output logic              flush,
   input  logic [IDX_W-1:0]  q_idx,
   output logic              q_ready,
   output logic [DATA_W-1:0] q_data,
   output logic [IDX_W:0]    count
);

   // Per-entry state. busy/ready are packed so they can be cleared in one go.
   logic [DEPTH-1:0]  busy_reg;
   logic [DEPTH-1:0]  ready_reg;
   logic [3:0]        func_reg [DEPTH];
   logic [3:0]        rd_reg   [DEPTH];
   logic [DATA_W-1:0] data_reg [DEPTH];

   logic [IDX_W-1:0]  head_reg;
   logic [IDX_W-1:0]  tail_reg;
   logic [IDX_W:0]    count_reg;

   logic              commit_valid_reg;
   logic              commit_we_reg;
   logic [3:0]        commit_rd_reg;
   logic [DATA_W-1:0] commit_data_reg;
   logic [IDX_W-1:0]  commit_rob_ind_reg;
   logic              flush_reg;

   logic              alloc_fire;
   logic              commit_fire;
   logic [3:0]        head_func;
   logic [DATA_W-1:0] head_data;
   logic              head_is_branch;
   logic              head_mispredict;
   logic              head_writes_reg;
   logic [IDX_W:0]    count_next;

   logic [DEPTH-1:0]  alloc_hit;
   logic [DEPTH-1:0]  wb_hit;
   logic [DEPTH-1:0]  commit_hit;

   // Full is judged on the registered count only, so a same-cycle commit
   // never opens a slot for the allocate in that cycle.
   assign alloc_ready = (count_reg != (IDX_W+1)'(DEPTH)) && !flush_reg;
   assign alloc_idx   = tail_reg;
   assign alloc_fire  = alloc_valid && alloc_ready;

   assign head_func       = func_reg[head_reg];
   assign head_data       = data_reg[head_reg];
   assign head_is_branch  = (head_func[3:1] == 3'b011);
   assign head_mispredict = head_is_branch && head_data[0];
   assign head_writes_reg = !(head_is_branch || (head_func == 4'b0101));

   // Retire only from registered ready state: no writeback-to-commit bypass.
   assign commit_fire = !flush_reg && busy_reg[head_reg] && ready_reg[head_reg];

   // Per-entry event decode. A writeback only lands on an entry that was
   // already busy before this edge, so it cannot hit a same-cycle allocate.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign alloc_hit[gi]  = alloc_fire  && (tail_reg   == IDX_W'(gi));
      assign wb_hit[gi]     = wb_valid    && (wb_rob_ind == IDX_W'(gi)) && busy_reg[gi];
      assign commit_hit[gi] = commit_fire && (head_reg   == IDX_W'(gi));
   end

   always_comb begin
      count_next = count_reg;
      unique case ({alloc_fire, commit_fire})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         busy_reg           <= '0;
         ready_reg          <= '0;
         head_reg           <= '0;
         tail_reg           <= '0;
         count_reg          <= '0;
         commit_valid_reg   <= 1'b0;
         commit_we_reg      <= 1'b0;
         commit_rd_reg      <= '0;
         commit_data_reg    <= '0;
         commit_rob_ind_reg <= '0;
         flush_reg          <= 1'b0;
      end else if (flush_reg) begin
         // Flush cycle: drop every in-flight entry and restart at index 0.
         // Allocates are blocked and writebacks are discarded here.
         busy_reg         <= '0;
         ready_reg        <= '0;
         head_reg         <= '0;
         tail_reg         <= '0;
         count_reg        <= '0;
         commit_valid_reg <= 1'b0;
         commit_we_reg    <= 1'b0;
         flush_reg        <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc_hit[i]) begin
               busy_reg[i]  <= 1'b1;
               ready_reg[i] <= 1'b0;
               func_reg[i]  <= alloc_func;
               rd_reg[i]    <= alloc_rd;
               data_reg[i]  <= '0;
            end else if (wb_hit[i]) begin
               data_reg[i]  <= wb_data;
               ready_reg[i] <= 1'b1;
            end
            // Head and tail only coincide when empty or full, so a retire
            // never collides with an allocate of the same slot.
            if (commit_hit[i]) begin
               busy_reg[i] <= 1'b0;
            end
         end

         if (alloc_fire) begin
            tail_reg <= tail_reg + 1'b1;
         end

         if (commit_fire) begin
            head_reg           <= head_reg + 1'b1;
            commit_valid_reg   <= 1'b1;
            commit_we_reg      <= head_writes_reg;
            commit_rd_reg      <= rd_reg[head_reg];
            commit_data_reg    <= head_data;
            commit_rob_ind_reg <= head_reg;
            flush_reg          <= head_mispredict;
         end else begin
            commit_valid_reg <= 1'b0;
            commit_we_reg    <= 1'b0;
            flush_reg        <= 1'b0;
         end

         count_reg <= count_next;
      end
   end

   assign commit_valid   = commit_valid_reg;
   assign commit_we      = commit_we_reg;
   assign commit_rd      = commit_rd_reg;
   assign commit_data    = commit_data_reg;
   assign commit_rob_ind = commit_rob_ind_reg;
   assign flush          = flush_reg;
   assign count          = count_reg;

   assign q_ready = busy_reg[q_idx] && ready_reg[q_idx];
   assign q_data  = busy_reg[q_idx] ? data_reg[q_idx] : '0;

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- 8-entry circular reorder buffer for the Tomasulo core.
- Sits downstream of the reservation-station/exec path.
- Allocates a ROB index at issue and captures results that exec broadcasts by ROB index.
- Retires results in program order to the register bank (one per cycle) and flushes on a mispredicted branch.
- Also supplies the issue stage with operand-forwarding lookups by ROB index.

Parameters:
- DEPTH, 8: number of entries; power of two.
- IDX_W, 3: ROB index width; log2(DEPTH).
- DATA_W, 16: result/register data width.

Ports:
- clk1  in  1  single clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  issue requests an entry this cycle.
- alloc_func  in  4  opcode: 0000/0001 add/sub, 0010/0011 mul/div, 0100 load, 0101 store, 0110/0111 branch.
- alloc_rd  in  4  destination register.
- alloc_ready  out  1  combinational, = (count != DEPTH) && !flush.
- alloc_idx  out  IDX_W  combinational, = tail; the index granted when alloc_valid && alloc_ready.
- wb_valid  in  1  exec result broadcast.
- wb_rob_ind  in  IDX_W  entry the result belongs to.
- wb_data  in  DATA_W  result; for branches bit0 = mispredict.
- commit_valid  out  1  registered, one-cycle pulse per retired entry.
- commit_we  out  1  registered; 1 when the retired entry writes regbank (not store, not branch).
- commit_rd  out  4  registered destination register.
- commit_data  out  DATA_W  registered result.
- commit_rob_ind  out  IDX_W  registered index of the retired entry.
- flush  out  1  registered, one-cycle pulse after retiring a mispredicted branch.
- q_idx  in  IDX_W  operand lookup index.
- q_ready  out  1  combinational; entry busy && result ready.
- q_data  out  DATA_W  combinational; entry data (0 if not busy).
- count  out  IDX_W+1  occupied entries, 0..DEPTH.

Behaviour:
- Entry fields: busy, ready, func, rd, data.
- Pointers: head, tail (IDX_W bits, wrap modulo DEPTH); count.
- Reset (synchronous, rst=1 at edge):
  - busy/ready cleared.
  - head = tail = count = 0.
  - commit_valid, commit_we, flush = 0; commit_rd, commit_data, commit_rob_ind = 0.
  - Reset overrides every other event in that cycle, including mid-flush.
- Allocate (alloc_valid && alloc_ready at edge):
  - entry[tail] <= {busy=1, ready=0, func, rd, data=0}.
  - tail <= tail+1.
  - Full is judged on the pre-edge count; a commit in the same cycle does not free a slot for that cycle's allocate.
- Writeback (wb_valid at edge):
  - If entry[wb_rob_ind].busy: data <= wb_data, ready <= 1.
  - Ignored if the entry is not busy, including an entry being allocated in that same cycle.
  - A second writeback to an already-ready entry overwrites data.
- Commit, evaluated at each edge when !flush && entry[head].busy && entry[head].ready:
  - commit_valid <= 1; commit_rd/commit_data/commit_rob_ind <= head's fields.
  - commit_we <= 1 unless func is 0101, 0110 or 0111.
  - entry[head].busy <= 0; head <= head+1.
  - Otherwise commit_valid <= 0 and commit_we <= 0.
- Latency:
  - Writeback at edge N makes the entry ready after N.
  - The earliest commit pulse is registered at edge N+1. No writeback-to-commit bypass.
- Branch mispredict:
  - If the committing entry has func 0110/0111 and data[0]=1, flush <= 1 at the same edge the commit pulse is registered.
  - During the flush cycle: alloc_ready=0, no commit.
  - At the next edge: all busy/ready <= 0, head <= tail <= 0, count <= 0, flush <= 0.
  - Writebacks during the flush cycle are discarded.
  - A branch with data[0]=0 commits normally.
- Count: updated as +1 on allocate, −1 on commit, unchanged when both or neither occur; never exceeds DEPTH or goes below 0.
- Wrap: pointers roll from 7 to 0 with no gap. With count == DEPTH, head == tail, and occupancy is distinguished by count, not by the pointers.

Test Plan:
- Reset then allocate add (rd=3), writeback data 0x0012 at idx 0 -> one cycle later commit_valid=1, commit_we=1, commit_rd=3, commit_data=0x0012, commit_rob_ind=0; count returns to 0.
- Out-of-order completion: allocate idx 0 (mul rd=1) and idx 1 (add rd=2); writeback idx1=0x0005, then idx0=0x0006 two cycles later -> commits are idx0 (rd=1, 0x0006) then idx1 (rd=2, 0x0005) on consecutive cycles; no commit before idx0 is ready.
- Fill 8 entries -> alloc_ready=0, count=8. Allocate while head commits in the same cycle -> the allocate is refused and count=7. Next cycle alloc_idx=0 (wrap) and the allocate is accepted.
- Store (0101, rd=4) and non-mispredicted branch (0110, data 0x0000) commit -> commit_valid=1 and commit_we=0 for both; flush stays 0.
- Mispredicted branch at idx 2 (data 0x0001) with idx 3,4 busy -> commit idx2 with flush=1; next cycle count=0, alloc_idx=0, q_ready for idx3=0; a writeback to idx3 during flush is ignored.
- q_idx=5 after writeback 0x00AB to idx5 -> q_ready=1, q_data=0x00AB. Assert rst with 3 entries busy -> next cycle count=0, commit_valid=0, flush=0.
